// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle control sequencer for the Pillar core.
// Walks each instruction through IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// driving a req/ready memory handshake with a bounded wait, and stops in HALT
// on a SYSTEM instruction or a bus-error timeout.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   mem_req_o/we/addr/wdata  memory request (we qualified by req)
//   mem_rdata_i, mem_ready_i read data and request completion
//   pc_i, pc_advance_o       fetch PC in, one-cycle PC-step pulse out
//   rs1_data_i, rs2_data_i   base register and store source values
//   ir_o, stage_o            instruction register, current stage code
//   ex_en_o, wb_en_o         execute / load-writeback strobes
//   wb_data_o                captured load data
//   halt_o, bus_err_o        halted flag, sticky bus-error flag
module multicycle_control #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned WAIT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ready_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_advance_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [31:0]     ir_o,
  output logic [2:0]      stage_o,
  output logic            ex_en_o,
  output logic            wb_en_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            halt_o,
  output logic            bus_err_o
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_MEMORY    = 3'd4;
  localparam logic [2:0] ST_WRITEBACK = 3'd5;
  localparam logic [2:0] ST_HALT      = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // A waiting cycle with this count is the last one allowed before timeout.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  logic [2:0]        state_q,    state_d;
  logic              mem_req_q,  mem_req_d;
  logic              mem_we_q,   mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   wdata_q,    wdata_d;
  logic [31:0]       ir_q,       ir_d;
  logic              pc_adv_q,   pc_adv_d;
  logic              ex_en_q,    ex_en_d;
  logic              wb_en_q,    wb_en_d;
  logic [XLEN-1:0]   wb_data_q,  wb_data_d;
  logic              halt_q,     halt_d;
  logic              bus_err_q,  bus_err_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic            is_load, is_store, is_system;
  logic            timeout, start_fetch;
  logic [XLEN-1:0] imm_i, imm_s;

  assign is_load   = (ir_q[6:0] == OP_LOAD);
  assign is_store  = (ir_q[6:0] == OP_STORE);
  assign is_system = (ir_q[6:0] == OP_SYSTEM);
  assign imm_i     = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s     = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  // Ready on the last allowed cycle completes the request, so it beats timeout.
  assign timeout   = mem_req_q && !mem_ready_i && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    ir_d        = ir_q;
    pc_adv_d    = 1'b0;
    ex_en_d     = 1'b0;
    wb_en_d     = 1'b0;
    wb_data_d   = wb_data_q;
    halt_d      = halt_q;
    bus_err_d   = bus_err_q;
    wait_cnt_d  = wait_cnt_q;
    start_fetch = 1'b0;

    if (mem_req_q && !mem_ready_i) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: start_fetch = 1'b1;
      ST_FETCH: begin
        if (mem_ready_i) begin
          ir_d      = mem_rdata_i[31:0];
          pc_adv_d  = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_DECODE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          halt_d    = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (is_system) begin
          halt_d  = 1'b1;
          state_d = ST_HALT;
        end else begin
          ex_en_d = !is_load && !is_store;
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (is_load || is_store) begin
          mem_req_d  = 1'b1;
          mem_we_d   = is_store;
          mem_addr_d = rs1_data_i + (is_store ? imm_s : imm_i);
          if (is_store) begin
            wdata_d = rs2_data_i;
          end
          wait_cnt_d = '0;
          state_d    = ST_MEMORY;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        if (mem_ready_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (is_load) begin
            wb_data_d = mem_rdata_i;
            wb_en_d   = (ir_q[11:7] != 5'd0);
            state_d   = ST_WRITEBACK;
          end else begin
            start_fetch = 1'b1;
          end
        end else if (timeout) begin
          bus_err_d = 1'b1;
          halt_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_HALT;
        end
      end
      ST_WRITEBACK: start_fetch = 1'b1;
      ST_HALT: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new fetch latches pc_i once; the address then holds until ready.
    if (start_fetch) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = pc_i;
      wait_cnt_d = '0;
      state_d    = ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      ir_q       <= '0;
      pc_adv_q   <= 1'b0;
      ex_en_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_data_q  <= '0;
      halt_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      ir_q       <= ir_d;
      pc_adv_q   <= pc_adv_d;
      ex_en_q    <= ex_en_d;
      wb_en_q    <= wb_en_d;
      wb_data_q  <= wb_data_d;
      halt_q     <= halt_d;
      bus_err_q  <= bus_err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = wdata_q;
  assign pc_advance_o = pc_adv_q;
  assign ir_o         = ir_q;
  assign stage_o      = state_q;
  assign ex_en_o      = ex_en_q;
  assign wb_en_o      = wb_en_q;
  assign wb_data_o    = wb_data_q;
  assign halt_o       = halt_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle control sequencer for the Pillar core, successor to the fixed 5-stage controller.
- Drives a req/ready memory handshake with wait states and bus-error timeout.
- Holds the instruction register and decodes LOAD/STORE/SYSTEM.
- Generates PC-advance, execute and writeback strobes for the datapath.

Parameters:
- XLEN, 32, data/address/instruction width (≥32; instruction bits above 31 ignored)
- MEM_WAIT_MAX, 15, max cycles a request may wait for mem_ready_i before bus error (≥1)
- WAIT_W, 4, width of wait counter; must hold MEM_WAIT_MAX

Ports:
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  write enable, qualified by mem_req_o
- mem_addr_o  out  XLEN  memory address
- mem_wdata_o  out  XLEN  store data
- mem_rdata_i  in  XLEN  read data, valid when mem_ready_i=1
- mem_ready_i  in  1  completes the current request
- pc_i  in  XLEN  current PC from fetch unit
- pc_advance_o  out  1  one-cycle pulse: fetch unit steps PC
- rs1_data_i  in  XLEN  base register value
- rs2_data_i  in  XLEN  store source value
- ir_o  out  32  instruction register
- stage_o  out  3  0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE, 4 MEMORY, 5 WRITEBACK, 6 HALT
- ex_en_o  out  1  one-cycle pulse in EXECUTE for non-memory, non-SYSTEM instructions
- wb_en_o  out  1  one-cycle pulse in WRITEBACK for LOAD with rd≠0
- wb_data_o  out  XLEN  load data captured in MEMORY
- halt_o  out  1  high in HALT
- bus_err_o  out  1  sticky; set on timeout

Behaviour:
- All outputs are registered.
- Reset: state IDLE; all outputs 0 (ir_o=0, stage_o=0); wait counter 0. Reset has priority on any cycle, including mid-request; mem_req_o drops the next edge.
- IDLE: next cycle FETCH, unconditionally.
- FETCH:
  - mem_req_o=1, mem_we_o=0, mem_addr_o=pc_i (sampled on FETCH entry, held stable).
  - On a cycle with mem_ready_i=1: ir_o<=mem_rdata_i[31:0], pc_advance_o pulses next cycle, mem_req_o drops, go DECODE.
  - Zero-wait memory (ready asserted the cycle req is visible) gives a 1-cycle FETCH.
- DECODE:
  - opcode=ir[6:0]; 0000011 LOAD, 0100011 STORE, 1110011 SYSTEM, others ALU.
  - SYSTEM → HALT; otherwise → EXECUTE.
- EXECUTE:
  - LOAD: effective address = rs1_data_i + sext(ir[31:20]).
  - STORE: effective address = rs1_data_i + sext({ir[31:25],ir[11:7]}); wdata latched from rs2_data_i.
  - Address addition is modulo 2^XLEN; wrap is silent.
  - ALU: ex_en_o pulses, next WRITEBACK.
  - LOAD/STORE: next MEMORY.
- MEMORY:
  - mem_req_o=1, mem_we_o=1 for STORE, 0 for LOAD; address and wdata held stable until ready.
  - On mem_ready_i: LOAD captures wb_data_o<=mem_rdata_i and goes WRITEBACK; STORE goes FETCH.
- WRITEBACK: wb_en_o=1 for one cycle iff LOAD and ir[11:7]≠0 (ALU writeback is the datapath's job via ex_en_o); next FETCH.
- Instruction latency with zero-wait memory: ALU 4, STORE 4, LOAD 5 cycles FETCH-to-FETCH.
- mem_ready_i is ignored when mem_req_o=0.
- Wait counter:
  - Cleared on each request start; increments each cycle mem_req_o=1 and mem_ready_i=0.
  - If it reaches MEM_WAIT_MAX without ready: bus_err_o<=1, mem_req_o<=0, go HALT.
  - Ready on the same cycle the count hits MEM_WAIT_MAX wins; no error.
- HALT: halt_o=1, no requests, no strobes; exit only by reset; bus_err_o cleared only by reset.

Test Plan:
- Zero-wait ALU: pc_i=0x0, rdata=0x00500093, ready always 1 → ir_o=0x00500093, pc_advance_o one pulse, ex_en_o one pulse, stage 1,2,3,5,1; 4 cycles; wb_en_o stays 0.
- Load with 3 wait states: ir=0x0040A103 (lw x2,4(x1)), rs1=0x100, ready after 3 cycles in MEMORY → mem_addr_o=0x104, we=0, addr held stable throughout, wb_data_o=rdata, wb_en_o one pulse.
- Store wrap: ir=0xFE20AE23 (sw x2,-4(x1)), rs1=0x2, rs2=0xDEADBEEF → mem_addr_o=0xFFFFFFFE, mem_we_o=1, mem_wdata_o=0xDEADBEEF, no WRITEBACK, back to FETCH.
- Timeout: ready held 0 in FETCH → after 15 cycles bus_err_o=1, halt_o=1, stage_o=6, mem_req_o=0. Variant: ready exactly at cycle 15 → no error.
- SYSTEM: ir=0x00000073 → DECODE then HALT, no ex_en_o/wb_en_o; reset then restarts at FETCH.
- Reset mid-MEMORY: assert reset during a load wait → next edge all outputs 0, stage_o=0; late ready ignored.
